// File: rtl/control_pipe_pkg.sv
// Shared control-word definitions for the decode-to-writeback control pipeline.
package control_pipe_pkg;

  localparam logic [1:0] ADD_OPCODE    = 2'b00;
  localparam logic [1:0] SUB_OPCODE    = 2'b01;
  localparam logic [1:0] R_TYPE_OPCODE = 2'b10;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic       mem_read;
    logic       mem_write;
    logic       mem_2_reg;
    logic       reg_write;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // Stores and x0 destinations must never retire as register writes.
  function automatic logic wb_qualify(input logic reg_write, input logic mem_write,
                                      input logic [4:0] rd);
    return reg_write & ~mem_write & (rd != 5'd0);
  endfunction

endpackage

// File: rtl/control_pipe_stage_reg.sv
// One control pipeline register: control word plus destination index.
module ctrl_stage_reg
  import control_pipe_pkg::*;
(
  input  logic       clk,
  input  logic       arst,
  input  logic       i_load,
  input  logic       i_clear,
  input  ctrl_t      i_ctrl,
  input  logic [4:0] i_rd,
  output ctrl_t      o_ctrl,
  output logic [4:0] o_rd
);

  ctrl_t      r_ctrl;
  logic [4:0] r_rd;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_ctrl <= CTRL_BUBBLE;
      r_rd   <= 5'd0;
    end else if (i_load) begin
      if (i_clear) begin
        r_ctrl <= CTRL_BUBBLE;
        r_rd   <= 5'd0;
      end else begin
        r_ctrl <= i_ctrl;
        r_rd   <= i_rd;
      end
    end
  end

  assign o_ctrl = r_ctrl;
  assign o_rd   = r_rd;

endmodule

// File: rtl/control_pipe.sv
// ID/EX, EX/MEM, MEM/WB control pipeline with load-use stall, redirect flush
// and saturating stall/flush event counters.
module control_pipe
  import control_pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             enable,
  input  logic             id_valid,
  input  logic [1:0]       id_alu_op,
  input  logic             id_alu_src,
  input  logic             id_branch,
  input  logic             id_jump,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_mem_2_reg,
  input  logic             id_reg_write,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             ex_take,
  output logic [1:0]       ex_alu_op,
  output logic             ex_alu_src,
  output logic             ex_branch,
  output logic             ex_jump,
  output logic [4:0]       ex_rd,
  output logic             mem_mem_read,
  output logic             mem_mem_write,
  output logic             wb_reg_write,
  output logic             wb_mem_2_reg,
  output logic [4:0]       wb_rd,
  output logic             stall_if,
  output logic             flush_if_id,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_t            w_id_ctrl;
  ctrl_t            w_ex_ctrl;
  ctrl_t            w_mem_ctrl;
  ctrl_t            w_wb_ctrl;
  logic [4:0]       w_ex_rd;
  logic [4:0]       w_mem_rd;
  logic [4:0]       w_wb_rd;
  logic             w_load_use;
  logic             w_redirect;
  logic             w_id_clear;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_comb begin
    w_id_ctrl           = CTRL_BUBBLE;
    w_id_ctrl.alu_op    = id_alu_op;
    w_id_ctrl.alu_src   = id_alu_src;
    w_id_ctrl.branch    = id_branch;
    w_id_ctrl.jump      = id_jump;
    w_id_ctrl.mem_read  = id_mem_read;
    w_id_ctrl.mem_write = id_mem_write;
    w_id_ctrl.mem_2_reg = id_mem_2_reg;
    w_id_ctrl.reg_write = wb_qualify(id_reg_write, id_mem_write, id_rd);
  end

  assign w_load_use = id_valid & w_ex_ctrl.mem_read & w_ex_ctrl.reg_write &
                      (w_ex_rd != 5'd0) & ((w_ex_rd == id_rs1) | (w_ex_rd == id_rs2));
  assign w_redirect = (w_ex_ctrl.branch & ex_take) | w_ex_ctrl.jump;

  // A redirect squashes the hazarding instruction, so it also masks the stall.
  assign stall_if    = w_load_use & ~w_redirect;
  assign flush_if_id = w_redirect;
  assign w_id_clear  = ~id_valid | w_load_use | w_redirect;

  ctrl_stage_reg u_id_ex (
    .clk     (clk),
    .arst    (arst),
    .i_load  (enable),
    .i_clear (w_id_clear),
    .i_ctrl  (w_id_ctrl),
    .i_rd    (id_rd),
    .o_ctrl  (w_ex_ctrl),
    .o_rd    (w_ex_rd)
  );

  ctrl_stage_reg u_ex_mem (
    .clk     (clk),
    .arst    (arst),
    .i_load  (enable),
    .i_clear (1'b0),
    .i_ctrl  (w_ex_ctrl),
    .i_rd    (w_ex_rd),
    .o_ctrl  (w_mem_ctrl),
    .o_rd    (w_mem_rd)
  );

  ctrl_stage_reg u_mem_wb (
    .clk     (clk),
    .arst    (arst),
    .i_load  (enable),
    .i_clear (1'b0),
    .i_ctrl  (w_mem_ctrl),
    .i_rd    (w_mem_rd),
    .o_ctrl  (w_wb_ctrl),
    .o_rd    (w_wb_rd)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (enable) begin
      if (stall_if && r_stall_cnt != CNT_MAX)
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (flush_if_id && r_flush_cnt != CNT_MAX)
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign ex_alu_op     = w_ex_ctrl.alu_op;
  assign ex_alu_src    = w_ex_ctrl.alu_src;
  assign ex_branch     = w_ex_ctrl.branch;
  assign ex_jump       = w_ex_ctrl.jump;
  assign ex_rd         = w_ex_rd;
  assign mem_mem_read  = w_mem_ctrl.mem_read;
  assign mem_mem_write = w_mem_ctrl.mem_write;
  assign wb_reg_write  = w_wb_ctrl.reg_write;
  assign wb_mem_2_reg  = w_wb_ctrl.mem_2_reg;
  assign wb_rd         = w_wb_rd;
  assign stall_cnt     = r_stall_cnt;
  assign flush_cnt     = r_flush_cnt;

  // Fields that have no consumer once the entry reaches write-back.
  logic w_unused;
  assign w_unused = ^{w_wb_ctrl.alu_op, w_wb_ctrl.alu_src, w_wb_ctrl.branch,
                      w_wb_ctrl.jump, w_wb_ctrl.mem_read, w_wb_ctrl.mem_write};

endmodule
